// File: rtl/buffer_ah_pingpong.sv
// Two-bank NxN ping-pong buffer between the horizontal and vertical filter passes.
// Rows are written in; each block is read out as columns (transpose) or as rows.
module buffer_ah_pingpong #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 9
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_mode,
  input  logic [N*(DATA_WIDTH+2)-1:0]    in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N*(DATA_WIDTH+2)-1:0]    out_data,
  output logic                           out_first,
  output logic                           out_last
);

  // Per-bank state
  //   state    | meaning
  //   EMPTY    | free, next write (row 0) starts a block
  //   FILLING  | rows 1..N-1 still to be written
  //   FULL     | complete block, no vector read yet
  //   DRAINING | at least one vector read, more to go
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

  localparam int W  = DATA_WIDTH + 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  bank_state_t    bank_q [2];
  bank_state_t    bank_d [2];
  logic [1:0]     mode_q, mode_d;
  logic           wbank_q, wbank_d, rbank_q, rbank_d;
  logic [CW-1:0]  wrow_q, wrow_d, ridx_q, ridx_d;
  logic           wr_fire, rd_fire;
  logic [N*W-1:0] mem [2][N];
  logic [N*W-1:0] col_vec;

  // Ready/valid decode only registered state, so there is no out_ready -> in_ready path.
  assign in_ready  = (bank_q[wbank_q] == EMPTY) || (bank_q[wbank_q] == FILLING);
  assign out_valid = (bank_q[rbank_q] == FULL)  || (bank_q[rbank_q] == DRAINING);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  always_comb begin
    bank_d  = bank_q;
    mode_d  = mode_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wrow_d  = wrow_q;
    ridx_d  = ridx_q;
    if (wr_fire) begin
      if (wrow_q == '0) begin
        bank_d[wbank_q] = FILLING;
        mode_d[wbank_q] = in_mode;
      end
      if (wrow_q == LAST) begin
        bank_d[wbank_q] = FULL;
        wrow_d          = '0;
        wbank_d         = ~wbank_q;
      end else begin
        wrow_d = wrow_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (ridx_q == LAST) begin
        bank_d[rbank_q] = EMPTY;
        ridx_d          = '0;
        rbank_d         = ~rbank_q;
      end else begin
        bank_d[rbank_q] = DRAINING;
        ridx_d          = ridx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      mode_q    <= '0;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wrow_q    <= '0;
      ridx_q    <= '0;
    end else begin
      bank_q  <= bank_d;
      mode_q  <= mode_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wrow_q  <= wrow_d;
      ridx_q  <= ridx_d;
    end
  end

  // Sample storage is never cleared; a discarded partial block is simply overwritten.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[wbank_q][wrow_q] <= in_data;
  end

  for (genvar k = 0; k < N; k++) begin : g_col
    assign col_vec[k*W +: W] = mem[rbank_q][k][int'(ridx_q)*W +: W];
  end

  assign out_data  = !out_valid          ? '0 :
                     mode_q[rbank_q]     ? col_vec : mem[rbank_q][ridx_q];
  assign out_first = out_valid && (ridx_q == '0);
  assign out_last  = out_valid && (ridx_q == LAST);

endmodule

// File: tb/tb_buffer_ah_pingpong.sv
// Directed bench for buffer_ah_pingpong: table-driven blocks and spot values,
// plus hand-written latency, back-pressure, reset and mode-glitch sequences.
module tb_buffer_ah_pingpong;

  localparam int DW = 8;
  localparam int N  = 9;
  localparam int W  = DW + 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           in_mode;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;
  logic           out_first;
  logic           out_last;

  buffer_ah_pingpong #(.DATA_WIDTH(DW), .N(N)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N*W-1:0] data;
    int             j;
    int             blk;
  } exp_t;

  typedef struct {
    int base;
    bit mode;
    bit glitch;
  } blk_t;

  typedef struct {
    int blk;
    int j;
    int k;
    int exp;
  } spot_t;

  exp_t           q[$];
  logic [N*W-1:0] cap [16][N];
  int             checks = 0;
  int             errors = 0;
  int             blk_no = 0;
  logic           lat_pre, lat_post;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Vector j of a block: transpose gives lane k = sample(row k, col j), rows give sample(row j, col k).
  function automatic logic [N*W-1:0] mk_vec(input int base, input bit mode, input int j);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++)
      v[k*W +: W] = W'(mode ? base + 10*k + j : base + 10*j + k);
    return v;
  endfunction

  task automatic write_block(input int base, input bit mode, input bit glitch,
                             input int nrows, output int stalls);
    logic rdy;
    int   t;
    stalls = 0;
    if (nrows == N) begin
      for (int j = 0; j < N; j++) q.push_back('{data: mk_vec(base, mode, j), j: j, blk: blk_no});
      blk_no++;
    end
    for (int r = 0; r < nrows; r++) begin
      in_valid = 1'b1;
      in_data  = mk_vec(base, 1'b0, r);
      in_mode  = (glitch && (r % 2 == 1)) ? ~mode : mode;
      t = 0;
      forever begin
        @(negedge clock);
        rdy     = in_ready;
        lat_pre = out_valid;
        @(posedge clock);
        #1;
        if (rdy) break;
        stalls++;
        t++;
        if (t > 300) begin
          errors++;
          $display("FAIL write_timeout actual=no_ready expected=ready");
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "write stalled");
        end
      end
      lat_post = out_valid;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    chk("drain_empty", q.size(), 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_vec", out_data, '0);
        end else begin
          e = q.pop_front();
          chk($sformatf("blk%0d_vec%0d_data", e.blk, e.j), out_data, e.data);
          chk($sformatf("blk%0d_vec%0d_flags", e.blk, e.j), {out_first, out_last},
              {e.j == 0, e.j == N-1});
          if (e.blk < 16) cap[e.blk][e.j] = out_data;
        end
      end else if (!out_valid) begin
        chk("idle_zero", {out_data, out_first, out_last}, '0);
      end
    end
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL global_timeout actual=running expected=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    blk_t  stream_tbl [4];
    spot_t spot_tbl [9];
    int    st, stall_total, gaps, t;
    logic signed [W-1:0] lv;

    stream_tbl = '{'{0, 1'b1, 1'b0}, '{-300, 1'b0, 1'b0}, '{150, 1'b1, 1'b0}, '{250, 1'b0, 1'b0}};
    spot_tbl = '{'{0, 0, 0, 0},  '{0, 3, 5, 53}, '{0, 8, 1, 18}, '{0, 8, 8, 88}, '{0, 0, 7, 70},
                 '{1, 3, 5, 35}, '{1, 8, 1, 81}, '{1, 0, 8, 8},  '{1, 8, 8, 88}};

    reset = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_first, out_last}, 0);

    // Transpose then pass-through of the same block; out_valid must appear right after the 9th row.
    out_ready = 1'b1;
    write_block(0, 1'b1, 1'b0, N, st);
    chk("t1_lat_pre", lat_pre, 0);
    chk("t1_lat_post", lat_post, 1);
    drain();
    write_block(0, 1'b0, 1'b0, N, st);
    chk("t2_lat_pre", lat_pre, 0);
    chk("t2_lat_post", lat_post, 1);
    drain();
    foreach (spot_tbl[i]) begin
      lv = cap[spot_tbl[i].blk][spot_tbl[i].j][spot_tbl[i].k*W +: W];
      chk($sformatf("spot%0d", i), 128'(int'(lv)), 128'(spot_tbl[i].exp));
    end

    // Four back-to-back blocks with alternating modes.
    stall_total = 0;
    gaps = 0;
    fork
      begin
        foreach (stream_tbl[i]) begin
          write_block(stream_tbl[i].base, stream_tbl[i].mode, stream_tbl[i].glitch, N, st);
          stall_total += st;
        end
      end
      begin
        t = 0;
        do begin
          @(negedge clock);
          t++;
        end while (!out_valid && t < 100);
        repeat (4*N - 1) begin
          @(negedge clock);
          if (!out_valid) gaps++;
        end
      end
    join
    chk("stream_stalls", stall_total, 0);
    chk("stream_gaps", gaps, 0);
    drain();

    // Back-pressure: two full banks, 19th row held until the first bank empties.
    out_ready = 1'b0;
    write_block(100, 1'b1, 1'b0, N, st);
    write_block(200, 1'b0, 1'b0, N, st);
    chk("bp_full_ready", in_ready, 0);
    fork
      write_block(300, 1'b1, 1'b0, N, st);
      begin
        repeat (3) begin
          @(negedge clock);
          chk("bp_held_ready", in_ready, 0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        for (int i = 1; i <= N; i++) begin
          @(negedge clock);
          chk($sformatf("bp_ready_read%0d", i), in_ready, 0);
        end
        @(negedge clock);
        chk("bp_ready_after_9th", in_ready, 1);
      end
    join
    drain();

    // Reset with a full bank partly read and a partial block in the other bank.
    out_ready = 1'b0;
    write_block(300, 1'b1, 1'b0, N, st);
    write_block(0, 1'b0, 1'b0, 5, st);
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_flags", {out_first, out_last}, 0);
    out_ready = 1'b1;
    write_block(400, 1'b0, 1'b0, N, st);
    drain();

    // in_mode toggling on rows 1..8 must not affect the block's mode.
    write_block(100, 1'b1, 1'b1, N, st);
    write_block(-200, 1'b0, 1'b1, N, st);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
